// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;

   // Fill bit for LO after a divide by zero; replicated to WIDTH (all ones).
   localparam logic DIV0_LO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes at accept, result negation in FIX.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [WIDTH-1:0]   mag_a_o,
   output logic [WIDTH-1:0]   mag_b_o,
   output logic               neg_a_o,
   output logic               neg_b_o,
   input  logic               is_div_i,
   input  logic               neg_a_q_i,
   input  logic               neg_b_q_i,
   input  logic [2*WIDTH-1:0] acc_i,
   output logic [WIDTH-1:0]   hi_o,
   output logic [WIDTH-1:0]   lo_o
);
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign neg_a_o = signed_i & a_i[WIDTH-1];
   assign neg_b_o = signed_i & b_i[WIDTH-1];
   assign mag_a_o = neg_a_o ? -a_i : a_i;
   assign mag_b_o = neg_b_o ? -b_i : b_i;

   // Quotient follows the operand sign product, remainder follows the dividend.
   always_comb begin
      prod = (neg_a_q_i ^ neg_b_q_i) ? -acc_i : acc_i;
      quo  = (neg_a_q_i ^ neg_b_q_i) ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
      rem  = neg_a_q_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
      hi_o = is_div_i ? rem : prod[2*WIDTH-1:WIDTH];
      lo_o = is_div_i ? quo : prod[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift/add multiplier and restoring divider feeding the HI/LO pair.
// Signed operation is compiled in by defining MULDIV_SIGNED_EN.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               div0_q, div0_d;
   logic               div_zero_q, div_zero_d;

   logic               accept, b_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic [WIDTH:0]     mul_sum, rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_nx;
   logic [2*WIDTH-1:0] mul_step, div_step;

   assign accept = (state_q == ST_IDLE) && start && ((op == OP_MUL) || (op == OP_DIV));
   assign b_zero = (op == OP_DIV) && (b == '0);

`ifdef MULDIV_SIGNED_EN
   logic neg_a, neg_b, neg_a_q, neg_b_q;

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .signed_i  (signed_op),
      .a_i       (a),
      .b_i       (b),
      .mag_a_o   (mag_a),
      .mag_b_o   (mag_b),
      .neg_a_o   (neg_a),
      .neg_b_o   (neg_b),
      .is_div_i  (is_div_q),
      .neg_a_q_i (neg_a_q),
      .neg_b_q_i (neg_b_q),
      .acc_i     (acc_q),
      .hi_o      (fix_hi),
      .lo_o      (fix_lo)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else if (accept) begin
         neg_a_q <= neg_a;
         neg_b_q <= neg_b;
      end
   end
`else
   logic unused_signed;
   assign unused_signed = signed_op;
   assign mag_a  = a;
   assign mag_b  = b;
   assign fix_hi = acc_q[2*WIDTH-1:WIDTH];
   assign fix_lo = acc_q[WIDTH-1:0];
`endif

   // Shared accumulator: upper half is partial product / remainder, lower half
   // is multiplier bits / dividend-then-quotient bits.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_ge   = (rem_sh >= {1'b0, mb_q});
      rem_nx   = rem_ge ? WIDTH'(rem_sh - {1'b0, mb_q}) : rem_sh[WIDTH-1:0];
      div_step = {rem_nx, acc_q[WIDTH-2:0], rem_ge};
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      mb_d       = mb_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      div0_d     = div0_q;
      div_zero_d = div_zero_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_CALC;
               cnt_d    = CNT_W'(WIDTH - 1);
               // A zero divisor keeps the raw dividend so HI can return it untouched.
               acc_d    = {{WIDTH{1'b0}}, b_zero ? a : mag_a};
               mb_d     = mag_b;
               is_div_d = (op == OP_DIV);
               div0_d   = b_zero;
            end
         end
         ST_CALC: begin
            // Divide by zero spends a single busy cycle here, then completes.
            if (div0_q) begin
               state_d    = ST_DONE;
               hi_d       = acc_q[WIDTH-1:0];
               lo_d       = {WIDTH{DIV0_LO}};
               div_zero_d = 1'b1;
            end else begin
               acc_d = is_div_q ? div_step : mul_step;
               if (cnt_q == '0) state_d = ST_FIX;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         ST_FIX: begin
            state_d    = ST_DONE;
            hi_d       = fix_hi;
            lo_d       = fix_lo;
            div_zero_d = 1'b0;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mb_q       <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         div0_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mb_q       <= mb_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         div0_q     <= div0_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign done     = (state_q == ST_DONE);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus directed vectors.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         clear = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic         signed_op = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int n_assert = 0;
   int n_fail   = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .op        (op),
      .signed_op (signed_op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .div_zero  (div_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference result {hi, lo, div_zero} from plain arithmetic.
   function automatic logic [64:0] model(input logic [1:0] mop, input logic msg,
                                         input logic [W-1:0] ma, input logic [W-1:0] mb);
      logic [63:0] p;
      longint      x, y;
      logic        sg;
      sg = msg & SIGNED_EN;
      if (mop == OP_MUL) begin
         if (sg) p = 64'(longint'($signed(ma)) * longint'($signed(mb)));
         else    p = {32'b0, ma} * {32'b0, mb};
         return {p, 1'b0};
      end
      if (mb == '0) return {ma, 32'hFFFF_FFFF, 1'b1};
      if (sg) begin
         x = $signed(ma);
         y = $signed(mb);
         return {32'(x % y), 32'(x / y), 1'b0};
      end
      return {ma % mb, ma / mb, 1'b0};
   endfunction

   // Model timeline: t counts cycles since accept; done when t == lat.
   int          t   = 0;
   int          lat = 0;
   logic [64:0] p_res = '0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   logic        m_dz = 1'b0;

   always @(posedge clock or negedge clear) begin
      if (!clear) begin
         t    <= 0;
         lat  <= 0;
         m_hi <= '0;
         m_lo <= '0;
         m_dz <= 1'b0;
      end else if (t != 0) begin
         if (t < lat) begin
            t <= t + 1;
            if (t + 1 == lat) {m_hi, m_lo, m_dz} <= p_res;
         end else begin
            t <= 0;
         end
      end else if (start && (op == OP_MUL || op == OP_DIV)) begin
         p_res <= model(op, signed_op, a, b);
         lat   <= (op == OP_DIV && b == '0) ? 2 : W + 2;
         t     <= 1;
      end
   end

   always @(negedge clock) begin
      check("cmp_busy", busy, (t != 0 && t < lat));
      check("cmp_done", done, (t != 0 && t == lat));
      check("cmp_hi", hi, m_hi);
      check("cmp_lo", lo, m_lo);
      check("cmp_div_zero", div_zero, m_dz);
   end

   task automatic run_op(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int cyc, output int bcy);
      @(negedge clock);
      op = o; signed_op = s; a = x; b = y; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0; a = $urandom; b = $urandom; signed_op = ~s;
      cyc = 0; bcy = 0;
      do begin
         @(negedge clock);
         cyc++;
         if (busy) bcy++;
      end while (!done && cyc < 200);
      check("done_seen", done, 1'b1);
   endtask

   task automatic exp_op(input string nm, input logic [1:0] o, input logic s,
                         input logic [W-1:0] x, input logic [W-1:0] y, input int elat,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
      int cyc, bcy;
      run_op(o, s, x, y, cyc, bcy);
      check({nm, "_latency"}, cyc, elat);
      check({nm, "_busy_cycles"}, bcy, elat - 1);
      check({nm, "_hi"}, hi, eh);
      check({nm, "_lo"}, lo, el);
      check({nm, "_div_zero"}, div_zero, edz);
   endtask

   initial begin
      int ndone;
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_div_zero", div_zero, 1'b0);
      clear = 1'b1;

      exp_op("mul_small", OP_MUL, 1'b0, 32'h0000_000F, 32'h0000_0002, 34, 32'h0, 32'h1E, 1'b0);
      exp_op("mul_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h1, 1'b0);
      exp_op("div_100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
      exp_op("sdiv_m7_2", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
             SIGNED_EN ? 32'hFFFF_FFFF : 32'h1, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 1'b0);
      exp_op("div0", OP_DIV, 1'b0, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b1);
      exp_op("mul_after_div0", OP_MUL, 1'b0, 32'd3, 32'd4, 34, 32'h0, 32'd12, 1'b0);
      exp_op("smul_m3_5", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 34,
             SIGNED_EN ? 32'hFFFF_FFFF : 32'h4, 32'hFFFF_FFF1, 1'b0);
      exp_op("sdiv_minneg", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
             SIGNED_EN ? 32'h0 : 32'h8000_0000, SIGNED_EN ? 32'h8000_0000 : 32'h0, 1'b0);
      exp_op("sdiv0", OP_DIV, 1'b1, 32'hFFFF_FFF0, 32'd0, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

      // Reserved op must not start anything.
      @(negedge clock);
      op = 2'b10; a = 32'd1; b = 32'd1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("rsvd_op_ignored", busy, 1'b0);

      // Restart while busy is ignored; reset aborts without completion.
      @(negedge clock);
      op = OP_MUL; signed_op = 1'b0; a = 32'd7; b = 32'd9; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(negedge clock);
      op = OP_DIV; a = 32'd50; b = 32'd0; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("restart_ignored_busy", busy, 1'b1);
      repeat (4) @(negedge clock);
      @(posedge clock);
      #2 clear = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_div_zero", div_zero, 1'b0);
      repeat (2) @(negedge clock);
      clear = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check("no_done_after_abort", ndone, 0);
      exp_op("div_after_reset", OP_DIV, 1'b0, 32'd1000, 32'd10, 34, 32'h0, 32'd100, 1'b0);

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
